// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcodes, register names, IR field
// positions and the fetch FSM state encoding.
package instruction_fetch_unit_pkg;

  localparam logic [3:0] NOP  = 4'h0;
  localparam logic [3:0] STO  = 4'h1;
  localparam logic [3:0] LMUL = 4'h2;
  localparam logic [3:0] LED  = 4'h3;
  localparam logic [3:0] ADD  = 4'h4;
  localparam logic [3:0] JMP  = 4'h5;

  localparam logic [7:0] R1 = 8'd1;
  localparam logic [7:0] R2 = 8'd2;
  localparam logic [7:0] R3 = 8'd3;
  localparam logic [7:0] R4 = 8'd4;
  localparam logic [7:0] R5 = 8'd5;
  localparam logic [7:0] R6 = 8'd6;
  localparam logic [7:0] R7 = 8'd7;

  localparam int OP_MSB   = 27;
  localparam int DEST_MSB = 23;
  localparam int SRCA_MSB = 15;
  localparam int SRCB_MSB = 7;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [27:0] nop_word();
    return {NOP, 24'd0};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_pc_register.sv
// Program counter with load (redirect), increment (modulo 2^ADDR_WIDTH) and hold.
module instruction_fetch_unit_pc_register #(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic [ADDR_WIDTH-1:0] load_value_i,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] pc_o
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_d;

  // Load has priority; increment wraps silently at the top of the address space.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_value_i;
    end else if (inc_i) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: drives ROM address from the PC, registers the returned word into
// the IR and slices it into decode fields. Handles stall, redirect and boot.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int INSN_WIDTH = 28,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  output logic [ADDR_WIDTH-1:0] oRomAddress,
  input  logic [INSN_WIDTH-1:0] iRomInstruction,
  input  logic                  iStall,
  input  logic                  iBranchTaken,
  input  logic [ADDR_WIDTH-1:0] iBranchTarget,
  output logic [INSN_WIDTH-1:0] oInstruction,
  output logic [ADDR_WIDTH-1:0] oInstrPC,
  output logic                  oValid,
  output logic [3:0]            oOperation,
  output logic [7:0]            oDestination,
  output logic [7:0]            oSourceA,
  output logic [7:0]            oSourceB,
  output logic [15:0]           oImmediate,
  output logic [1:0]            oState
);

  fetch_state_e          state_q, state_d;
  logic [INSN_WIDTH-1:0] ir_q, ir_d;
  logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic                  valid_q, valid_d;
  logic                  pc_load;
  logic                  pc_inc;
  logic [ADDR_WIDTH-1:0] pc;

  instruction_fetch_unit_pc_register #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .RESET_PC  (RESET_PC)
  ) u_pc (
    .clk         (Clock),
    .rst         (Reset),
    .load_i      (pc_load),
    .load_value_i(iBranchTarget),
    .inc_i       (pc_inc),
    .pc_o        (pc)
  );

  // RUN and FLUSH share priority: redirect, then stall, then capture.
  // BOOT never captures and ignores redirects.
  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = RUN;
      end
      RUN, FLUSH: begin
        if (iBranchTaken) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          ir_d    = nop_word();
          state_d = FLUSH;
        end else if (!iStall) begin
          ir_d       = iRomInstruction;
          instr_pc_d = pc;
          valid_d    = 1'b1;
          pc_inc     = 1'b1;
          state_d    = RUN;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= BOOT;
      ir_q       <= nop_word();
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
    end
  end

  assign oRomAddress  = pc;
  assign oInstruction = ir_q;
  assign oInstrPC     = instr_pc_q;
  assign oValid       = valid_q;
  assign oOperation   = ir_q[OP_MSB -: 4];
  assign oDestination = ir_q[DEST_MSB -: 8];
  assign oSourceA     = ir_q[SRCA_MSB -: 8];
  assign oSourceB     = ir_q[SRCB_MSB -: 8];
  assign oImmediate   = ir_q[SRCA_MSB -: 16];
  assign oState       = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: boot, stall, redirect, wrap and
// asynchronous reset, checked with immediate assertions against hand values.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        Clock;
  logic        Reset;
  logic [15:0] oRomAddress;
  logic [27:0] iRomInstruction;
  logic        iStall;
  logic        iBranchTaken;
  logic [15:0] iBranchTarget;
  logic [27:0] oInstruction;
  logic [15:0] oInstrPC;
  logic        oValid;
  logic [3:0]  oOperation;
  logic [7:0]  oDestination;
  logic [7:0]  oSourceA;
  logic [7:0]  oSourceB;
  logic [15:0] oImmediate;
  logic [1:0]  oState;

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit dut (
    .Clock          (Clock),
    .Reset          (Reset),
    .oRomAddress    (oRomAddress),
    .iRomInstruction(iRomInstruction),
    .iStall         (iStall),
    .iBranchTaken   (iBranchTaken),
    .iBranchTarget  (iBranchTarget),
    .oInstruction   (oInstruction),
    .oInstrPC       (oInstrPC),
    .oValid         (oValid),
    .oOperation     (oOperation),
    .oDestination   (oDestination),
    .oSourceA       (oSourceA),
    .oSourceB       (oSourceB),
    .oImmediate     (oImmediate),
    .oState         (oState)
  );

  // Clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ROM stub
  always_comb begin
    case (oRomAddress)
      16'h0000: iRomInstruction = {NOP, 24'd4000};
      16'h0001: iRomInstruction = {STO, R1, 16'd21896};
      16'h0002: iRomInstruction = {ADD, R2, R3, R4};
      16'h0003: iRomInstruction = {LMUL, R1, R1, R7};
      default:  iRomInstruction = {LED, 8'h00, oRomAddress};
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic boot_sequence();
    chk("boot_state_pre", 32'(oState), 32'(BOOT));
    step();
    chk("e1_valid", 32'(oValid), 32'd0);
    chk("e1_addr", 32'(oRomAddress), 32'd0);
    chk("e1_state", 32'(oState), 32'(RUN));
    step();
    chk("e2_ir", 32'(oInstruction), 32'({NOP, 24'd4000}));
    chk("e2_ipc", 32'(oInstrPC), 32'd0);
    chk("e2_valid", 32'(oValid), 32'd1);
    chk("e2_addr", 32'(oRomAddress), 32'd1);
    step();
    chk("e3_op", 32'(oOperation), 32'(STO));
    chk("e3_dest", 32'(oDestination), 32'(R1));
    chk("e3_imm", 32'(oImmediate), 32'd21896);
    chk("e3_ipc", 32'(oInstrPC), 32'd1);
  endtask

  initial begin
    Reset = 1'b1;
    iStall = 1'b0;
    iBranchTaken = 1'b0;
    iBranchTarget = 16'h0000;
    #12;
    chk("rst_addr", 32'(oRomAddress), 32'd0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_ir", 32'(oInstruction), 32'({NOP, 24'd0}));
    @(negedge Clock);
    Reset = 1'b0;

    // Boot and first fetches
    boot_sequence();

    // Capture address 2, PC moves to 3, then stall 3 cycles
    step();
    chk("pre_stall_addr", 32'(oRomAddress), 32'd3);
    chk("pre_stall_ipc", 32'(oInstrPC), 32'd2);
    iStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ir", 32'(oInstruction), 32'({ADD, R2, R3, R4}));
      chk("stall_ipc", 32'(oInstrPC), 32'd2);
      chk("stall_valid", 32'(oValid), 32'd1);
      chk("stall_addr", 32'(oRomAddress), 32'd3);
    end
    iStall = 1'b0;
    step();
    chk("post_stall_op", 32'(oOperation), 32'(LMUL));
    chk("post_stall_srca", 32'(oSourceA), 32'(R1));
    chk("post_stall_srcb", 32'(oSourceB), 32'(R7));
    chk("post_stall_ipc", 32'(oInstrPC), 32'd3);
    step();
    chk("pc5", 32'(oRomAddress), 32'd5);

    // Redirect to 0x0010 at PC=5
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0010;
    step();
    iBranchTaken = 1'b0;
    chk("br_valid", 32'(oValid), 32'd0);
    chk("br_addr", 32'(oRomAddress), 32'h10);
    chk("br_ir", 32'(oInstruction), 32'({NOP, 24'd0}));
    chk("br_state", 32'(oState), 32'(FLUSH));
    step();
    chk("br_ipc", 32'(oInstrPC), 32'h10);
    chk("br_valid2", 32'(oValid), 32'd1);
    chk("br_ir2", 32'(oInstruction), 32'({LED, 8'h00, 16'h0010}));
    chk("br_addr2", 32'(oRomAddress), 32'h11);

    // Branch and stall together: branch wins
    iBranchTaken = 1'b1;
    iStall = 1'b1;
    iBranchTarget = 16'h0020;
    step();
    iBranchTaken = 1'b0;
    iStall = 1'b0;
    chk("bs_valid", 32'(oValid), 32'd0);
    chk("bs_addr", 32'(oRomAddress), 32'h20);
    step();
    chk("bs_ipc", 32'(oInstrPC), 32'h20);
    chk("bs_valid2", 32'(oValid), 32'd1);

    // Stall while in FLUSH keeps the bubble, then redirect again from FLUSH
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0030;
    step();
    iBranchTaken = 1'b0;
    iStall = 1'b1;
    step();
    chk("fs_state", 32'(oState), 32'(FLUSH));
    chk("fs_valid", 32'(oValid), 32'd0);
    chk("fs_addr", 32'(oRomAddress), 32'h30);
    iStall = 1'b0;
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0040;
    step();
    iBranchTaken = 1'b0;
    chk("rr_state", 32'(oState), 32'(FLUSH));
    chk("rr_addr", 32'(oRomAddress), 32'h40);
    step();
    chk("rr_ipc", 32'(oInstrPC), 32'h40);

    // Wrap-around
    iBranchTaken = 1'b1;
    iBranchTarget = 16'hFFFF;
    step();
    iBranchTaken = 1'b0;
    chk("wr_addr0", 32'(oRomAddress), 32'hFFFF);
    step();
    chk("wr_ipc1", 32'(oInstrPC), 32'hFFFF);
    chk("wr_addr1", 32'(oRomAddress), 32'h0000);
    step();
    chk("wr_ipc2", 32'(oInstrPC), 32'h0000);
    chk("wr_addr2", 32'(oRomAddress), 32'h0001);
    chk("wr_ir2", 32'(oInstruction), 32'({NOP, 24'd4000}));

    // Asynchronous reset mid-FLUSH
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0050;
    step();
    iBranchTaken = 1'b0;
    chk("ar_state_pre", 32'(oState), 32'(FLUSH));
    #2;
    Reset = 1'b1;
    #1;
    chk("ar_addr", 32'(oRomAddress), 32'd0);
    chk("ar_valid", 32'(oValid), 32'd0);
    chk("ar_ir", 32'(oInstruction), 32'({NOP, 24'd0}));
    chk("ar_ipc", 32'(oInstrPC), 32'd0);
    chk("ar_state", 32'(oState), 32'(BOOT));
    @(negedge Clock);
    Reset = 1'b0;
    boot_sequence();

    // Branch during BOOT is ignored
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    Reset = 1'b0;
    iBranchTaken = 1'b1;
    iBranchTarget = 16'h0077;
    step();
    iBranchTaken = 1'b0;
    chk("bb_addr", 32'(oRomAddress), 32'd0);
    chk("bb_state", 32'(oState), 32'(RUN));
    step();
    chk("bb_valid", 32'(oValid), 32'd1);
    chk("bb_ipc", 32'(oInstrPC), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
